// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel programmable tick/square divider
// Each channel counts 0..D and commits shadowed divisor writes only on a terminal or sync.
module clock_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 125000000,
    parameter int SEL_W       = 2
) (
    input  logic                CLK_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync,
    input  logic                div_we,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_data,
    input  logic                div_mode,
    output logic [CHANNELS-1:0] CLK_out,
    output logic [CHANNELS-1:0] tc,
    output logic [CHANNELS-1:0] div_pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    for (genvar c = 0; c < CHANNELS; c++) begin : ch
        localparam logic [SEL_W-1:0] IDX = SEL_W'(c);

        logic [WIDTH-1:0] count_q, count_d;
        logic [WIDTH-1:0] act_div_q, act_div_d;
        logic [WIDTH-1:0] sh_div_q, sh_div_d;
        logic             act_mode_q, act_mode_d;
        logic             sh_mode_q, sh_mode_d;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tc_q, tc_d;
        logic             wr;
        logic             term;

        assign wr   = div_we && (div_sel == IDX);
        assign term = enable[c] && (count_q == act_div_q);

        always_comb begin
            count_d    = count_q;
            act_div_d  = act_div_q;
            act_mode_d = act_mode_q;
            sh_div_d   = sh_div_q;
            sh_mode_d  = sh_mode_q;
            pend_d     = pend_q;
            clk_d      = clk_q;
            tc_d       = 1'b0;
            if (sync) begin
                count_d = '0;
                clk_d   = 1'b0;
                pend_d  = 1'b0;
                if (wr) begin
                    // Same-cycle write is forwarded straight into the active set.
                    act_div_d  = div_data;
                    act_mode_d = div_mode;
                    sh_div_d   = div_data;
                    sh_mode_d  = div_mode;
                end else if (pend_q) begin
                    act_div_d  = sh_div_q;
                    act_mode_d = sh_mode_q;
                end
            end else begin
                if (term) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                    if (pend_q) begin
                        act_div_d  = sh_div_q;
                        act_mode_d = sh_mode_q;
                        pend_d     = 1'b0;
                    end
                    clk_d = act_mode_d ? ~clk_q : 1'b1;
                end else begin
                    if (enable[c]) begin
                        count_d = count_q + ONE;
                    end
                    clk_d = act_mode_q ? clk_q : 1'b0;
                end
                // A write landing on a terminal goes to the shadow after the old one commits.
                if (wr) begin
                    sh_div_d  = div_data;
                    sh_mode_d = div_mode;
                    pend_d    = 1'b1;
                end
            end
        end

        always_ff @(posedge CLK_in or negedge reset) begin
            if (!reset) begin
                count_q    <= '0;
                act_div_q  <= DEF_DIV;
                act_mode_q <= 1'b0;
                sh_div_q   <= DEF_DIV;
                sh_mode_q  <= 1'b0;
                pend_q     <= 1'b0;
                clk_q      <= 1'b0;
                tc_q       <= 1'b0;
            end else begin
                count_q    <= count_d;
                act_div_q  <= act_div_d;
                act_mode_q <= act_mode_d;
                sh_div_q   <= sh_div_d;
                sh_mode_q  <= sh_mode_d;
                pend_q     <= pend_d;
                clk_q      <= clk_d;
                tc_q       <= tc_d;
            end
        end

        assign CLK_out[c]     = clk_q;
        assign tc[c]          = tc_q;
        assign div_pending[c] = pend_q;
    end

endmodule
